ip_io_bus_hub: RTL and testbench

Parametrised I/O bus hub between the MSX slot bus bridge and up to eight I/O peripherals (VDP, PSG, debug registers and similar). It decodes each slot I/O transaction to one device and forwards it with a registered valid/ready handshake. It returns read data with an aborting timeout, and aggregates device interrupts. It replaces the fixed single-device rdata/ready wiring at the cartridge top level.

---
 rtl/ip_io_bus_pkg.sv | 26 ++
 rtl/ip_io_bus_decoder.sv | 37 +++
 rtl/ip_io_bus_hub.sv | 215 +++++++++++++++++++++
 tb/tb_ip_io_bus_hub.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_io_bus_pkg.sv
// ip_io_bus_pkg
//   Shared definitions for the I/O bus hub: the FSM state encoding and the
//   per-device address match function used by the decoder.
package ip_io_bus_pkg;

  // Widest I/O address the match helper handles. Narrower addresses are
  // zero-extended by the caller. Zero-extended mask bits are 0, so the
  // extra upper bits are never compared.
  localparam int ADDR_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } hub_state_e;

  // A device matches when every address bit selected by its mask equals
  // the corresponding bit of its base.
  function automatic logic addr_match(input logic [ADDR_MAX-1:0] addr,
                                      input logic [ADDR_MAX-1:0] base,
                                      input logic [ADDR_MAX-1:0] mask);
    return ((addr ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/ip_io_bus_decoder.sv
// ip_io_bus_decoder
//   Combinational address decoder. When several devices match, the lowest
//   index wins.
// Ports:
//   addr_i  in   ADDR_W  address to decode
//   sel_o   out  N_DEV   one-hot select of the winning device (0 on miss)
//   hit_o   out  1       at least one device matched
module ip_io_bus_decoder
  import ip_io_bus_pkg::*;
#(
  parameter int                      N_DEV    = 2,
  parameter int                      ADDR_W   = 8,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE = {N_DEV{8'h98}},
  parameter logic [N_DEV*ADDR_W-1:0] DEV_MASK = {N_DEV{8'hFC}}
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [N_DEV-1:0]  sel_o,
  output logic              hit_o
);

  // Scan from the highest index down so that a lower-index match
  // overwrites any higher one.
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int k = N_DEV - 1; k >= 0; k--) begin
      if (addr_match(ADDR_MAX'(addr_i),
                     ADDR_MAX'(DEV_BASE[k*ADDR_W +: ADDR_W]),
                     ADDR_MAX'(DEV_MASK[k*ADDR_W +: ADDR_W]))) begin
        sel_o    = '0;
        sel_o[k] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_io_bus_hub.sv
// ip_io_bus_hub
//   Hub between the slot-bus bridge and up to eight I/O peripherals.
//   Decodes each upstream I/O transaction to one device, forwards it with a
//   registered request, returns read data (or DEFAULT_RDATA on unmapped
//   reads and timeouts), and ANDs the device interrupts.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   bus_*                        upstream request / response
//   dev_address/ioreq/write/wdata shared downstream request fields
//   dev_valid, dev_ready         per-device request handshake
//   dev_rdata, dev_rdata_en      per-device read data and strobe
//   dev_int_n, int_n             device interrupts in, registered AND out
//   timeout_flag, timeout_clear  sticky timeout indication and its clear
//   dbg_state                    current FSM state (hub_state_e encoding)
//
// Handshake: upstream, a request transfers on a cycle where bus_valid and
// bus_ready are both high; bus_ready is high only in IDLE. Downstream,
// dev_valid[k] and all dev_* fields are held stable until a cycle where
// dev_ready[k] is high (that cycle completes the transfer) or the timeout
// expires. Read data is returned by a one-cycle dev_rdata_en[k] strobe on
// or after the accepting cycle, and upstream by a one-cycle bus_rdata_en.
module ip_io_bus_hub
  import ip_io_bus_pkg::*;
#(
  parameter int                      N_DEV         = 2,
  parameter int                      ADDR_W        = 8,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE      = {N_DEV{8'h98}},
  parameter logic [N_DEV*ADDR_W-1:0] DEV_MASK      = {N_DEV{8'hFC}},
  parameter int                      TIMEOUT       = 255,
  parameter logic [7:0]              DEFAULT_RDATA = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    bus_address,
  input  logic                 bus_ioreq,
  input  logic                 bus_write,
  input  logic                 bus_valid,
  output logic                 bus_ready,
  input  logic [7:0]           bus_wdata,
  output logic [7:0]           bus_rdata,
  output logic                 bus_rdata_en,
  output logic [ADDR_W-1:0]    dev_address,
  output logic                 dev_ioreq,
  output logic                 dev_write,
  output logic [7:0]           dev_wdata,
  output logic [N_DEV-1:0]     dev_valid,
  input  logic [N_DEV-1:0]     dev_ready,
  input  logic [N_DEV*8-1:0]   dev_rdata,
  input  logic [N_DEV-1:0]     dev_rdata_en,
  input  logic [N_DEV-1:0]     dev_int_n,
  output logic                 int_n,
  output logic                 timeout_flag,
  input  logic                 timeout_clear,
  output logic [1:0]           dbg_state
);

  // With TIMEOUT=0 the counter is unused; keep it one bit wide.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  hub_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              ioreq_q;
  logic              write_q;
  logic [7:0]        wdata_q;
  logic [N_DEV-1:0]  sel_q;
  logic [N_DEV-1:0]  dev_valid_q;
  logic [7:0]        rdata_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_flag_q;
  logic              int_n_q;

  logic [N_DEV-1:0]  dec_sel;
  logic              dec_hit;
  logic              accept;
  logic              ready_sel;
  logic              ren_sel;
  logic [7:0]        rdata_sel;
  logic [CNT_W:0]    cnt_inc;
  logic              expire;
  logic              tmo_evt;

  ip_io_bus_decoder #(
    .N_DEV    (N_DEV),
    .ADDR_W   (ADDR_W),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_decoder (
    .addr_i (bus_address),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  assign accept    = (state_q == ST_IDLE) && bus_valid;
  // Responses from devices other than the selected one are masked off here.
  assign ready_sel = |(dev_ready & sel_q);
  assign ren_sel   = |(dev_rdata_en & sel_q);

  always_comb begin
    rdata_sel = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (sel_q[k]) rdata_sel = dev_rdata[k*8 +: 8];
    end
  end

  // Timeout counter: zero outside REQ/RDWAIT, so it is zero on entry to REQ.
  // "expire" is the cycle in which the count reaches TIMEOUT; the counter
  // saturates there so a read accepted on the expiry cycle times out on the
  // next RDWAIT cycle without a data strobe.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    expire  = (TIMEOUT != 0) && (cnt_inc >= (CNT_W + 1)'(TIMEOUT));
    cnt_d   = '0;
    if ((state_q == ST_REQ) || (state_q == ST_RDWAIT)) begin
      cnt_d = expire ? CNT_W'(TIMEOUT) : cnt_inc[CNT_W-1:0];
    end
  end

  // A device response in the expiry cycle takes precedence over the timeout.
  assign tmo_evt = expire &&
                   (((state_q == ST_REQ) && !ready_sel) ||
                    ((state_q == ST_RDWAIT) && !ren_sel));

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_valid) begin
          if (dec_hit)         state_d = ST_REQ;
          else if (!bus_write) state_d = ST_RESP;
        end
      end
      ST_REQ: begin
        if (ready_sel) begin
          if (write_q)      state_d = ST_IDLE;
          else if (ren_sel) state_d = ST_RESP;
          else              state_d = ST_RDWAIT;
        end else if (expire) begin
          state_d = write_q ? ST_IDLE : ST_RESP;
        end
      end
      ST_RDWAIT: begin
        if (ren_sel || expire) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus_ready    = (state_q == ST_IDLE);
    bus_rdata_en = (state_q == ST_RESP);
    dbg_state    = state_q;
  end

  // Request latches, downstream valid, read capture, timeout, interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      ioreq_q     <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      sel_q       <= '0;
      dev_valid_q <= '0;
      rdata_q     <= DEFAULT_RDATA;
      cnt_q       <= '0;
      tmo_flag_q  <= 1'b0;
      int_n_q     <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      int_n_q <= &dev_int_n;

      if (accept) begin
        addr_q  <= bus_address;
        ioreq_q <= bus_ioreq;
        write_q <= bus_write;
        wdata_q <= bus_wdata;
        sel_q   <= dec_sel;
        if (dec_hit)         dev_valid_q <= dec_sel;
        else if (!bus_write) rdata_q     <= DEFAULT_RDATA;
      end

      if (state_q == ST_REQ) begin
        if (ready_sel || expire) dev_valid_q <= '0;
        if (ready_sel && ren_sel && !write_q) rdata_q <= rdata_sel;
      end

      if ((state_q == ST_RDWAIT) && ren_sel) rdata_q <= rdata_sel;

      if (tmo_evt && !write_q) rdata_q <= DEFAULT_RDATA;

      // Set has priority over clear.
      if (tmo_evt)            tmo_flag_q <= 1'b1;
      else if (timeout_clear) tmo_flag_q <= 1'b0;
    end
  end

  assign dev_address  = addr_q;
  assign dev_ioreq    = ioreq_q;
  assign dev_write    = write_q;
  assign dev_wdata    = wdata_q;
  assign dev_valid    = dev_valid_q;
  assign bus_rdata    = rdata_q;
  assign int_n        = int_n_q;
  assign timeout_flag = tmo_flag_q;

endmodule

// File: tb/tb_ip_io_bus_hub.sv
// tb_ip_io_bus_hub
//   Directed bench for ip_io_bus_hub. Main instance: bases 98h/A0h, masks
//   FCh, TIMEOUT=4. Second instance: default parameters (both devices at
//   98h/FCh) for the overlapping-decode case.
module tb_ip_io_bus_hub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic [7:0]  bus_address;
  logic        bus_ioreq, bus_write, bus_valid, bus_ready;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        bus_rdata_en;
  logic [7:0]  dev_address;
  logic        dev_ioreq, dev_write;
  logic [7:0]  dev_wdata;
  logic [1:0]  dev_valid, dev_ready, dev_rdata_en, dev_int_n;
  logic [15:0] dev_rdata;
  logic        int_n, timeout_flag, timeout_clear;
  logic [1:0]  dbg_state;

  ip_io_bus_hub #(
    .N_DEV         (2),
    .ADDR_W        (8),
    .DEV_BASE      ({8'hA0, 8'h98}),
    .DEV_MASK      ({8'hFC, 8'hFC}),
    .TIMEOUT       (4),
    .DEFAULT_RDATA (8'hFF)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus_address   (bus_address),
    .bus_ioreq     (bus_ioreq),
    .bus_write     (bus_write),
    .bus_valid     (bus_valid),
    .bus_ready     (bus_ready),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_rdata_en  (bus_rdata_en),
    .dev_address   (dev_address),
    .dev_ioreq     (dev_ioreq),
    .dev_write     (dev_write),
    .dev_wdata     (dev_wdata),
    .dev_valid     (dev_valid),
    .dev_ready     (dev_ready),
    .dev_rdata     (dev_rdata),
    .dev_rdata_en  (dev_rdata_en),
    .dev_int_n     (dev_int_n),
    .int_n         (int_n),
    .timeout_flag  (timeout_flag),
    .timeout_clear (timeout_clear),
    .dbg_state     (dbg_state)
  );

  // ---------------- overlap DUT signals ----------------
  logic [7:0]  b_address;
  logic        b_ioreq, b_write, b_valid, b_ready;
  logic [7:0]  b_wdata, b_rdata;
  logic        b_rdata_en;
  logic [7:0]  b_dev_address;
  logic        b_dev_ioreq, b_dev_write;
  logic [7:0]  b_dev_wdata;
  logic [1:0]  b_dev_valid, b_dev_ready, b_dev_rdata_en, b_dev_int_n;
  logic [15:0] b_dev_rdata;
  logic        b_int_n, b_timeout_flag, b_timeout_clear;
  logic [1:0]  b_dbg_state;

  ip_io_bus_hub dut_ovl (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus_address   (b_address),
    .bus_ioreq     (b_ioreq),
    .bus_write     (b_write),
    .bus_valid     (b_valid),
    .bus_ready     (b_ready),
    .bus_wdata     (b_wdata),
    .bus_rdata     (b_rdata),
    .bus_rdata_en  (b_rdata_en),
    .dev_address   (b_dev_address),
    .dev_ioreq     (b_dev_ioreq),
    .dev_write     (b_dev_write),
    .dev_wdata     (b_dev_wdata),
    .dev_valid     (b_dev_valid),
    .dev_ready     (b_dev_ready),
    .dev_rdata     (b_dev_rdata),
    .dev_rdata_en  (b_dev_rdata_en),
    .dev_int_n     (b_dev_int_n),
    .int_n         (b_int_n),
    .timeout_flag  (b_timeout_flag),
    .timeout_clear (b_timeout_clear),
    .dbg_state     (b_dbg_state)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every upstream read-data strobe must match the next
  // expected read value.
  always @(negedge clk) begin
    if (reset_n && bus_rdata_en) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'(exp_q.size()), 1);
      else                   check("rd_scoreboard", {24'd0, bus_rdata}, {24'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic wr, input logic [7:0] wd, input logic io);
    bus_address = a;
    bus_write   = wr;
    bus_wdata   = wd;
    bus_ioreq   = io;
    bus_valid   = 1'b1;
  endtask

  task automatic bus_idle();
    bus_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus_address = '0; bus_ioreq = 0; bus_write = 0; bus_valid = 0; bus_wdata = '0;
    dev_ready = '0; dev_rdata = '0; dev_rdata_en = '0; dev_int_n = 2'b11; timeout_clear = 0;
    b_address = '0; b_ioreq = 0; b_write = 0; b_valid = 0; b_wdata = '0;
    b_dev_ready = '0; b_dev_rdata = '0; b_dev_rdata_en = '0; b_dev_int_n = 2'b11; b_timeout_clear = 0;

    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check("rst_bus_ready", bus_ready, 1);
    check("rst_bus_rdata", bus_rdata, 8'hFF);
    check("rst_rdata_en", bus_rdata_en, 0);
    check("rst_dev_valid", dev_valid, 0);
    check("rst_int_n", int_n, 1);
    check("rst_tflag", timeout_flag, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    tick();

    // Write 55h to 99h, device 0 ready immediately
    issue(8'h99, 1, 8'h55, 1);
    dev_ready = 2'b01;
    check("wr_accept_ready", bus_ready, 1);
    tick();  // T+1
    bus_idle();
    check("wr_dev_valid", dev_valid, 2'b01);
    check("wr_dev_address", dev_address, 8'h99);
    check("wr_dev_wdata", dev_wdata, 8'h55);
    check("wr_dev_write", dev_write, 1);
    check("wr_dev_ioreq", dev_ioreq, 1);
    check("wr_busy", bus_ready, 0);
    tick();  // T+2
    dev_ready = 2'b00;
    check("wr_done_ready", bus_ready, 1);
    check("wr_done_valid", dev_valid, 0);

    // Read A1h: device 1 ready at T+1, data 3Ch at T+4
    issue(8'hA1, 0, 8'h00, 1);
    exp_q.push_back(8'h3C);
    tick();  // T+1
    bus_idle();
    check("rd1_dev_valid", dev_valid, 2'b10);
    dev_ready = 2'b10;
    tick();  // T+2
    dev_ready = 2'b00;
    check("rd1_valid_drop", dev_valid, 0);
    check("rd1_state_rdwait", dbg_state, 2);
    tick();  // T+3
    tick();  // T+4
    dev_rdata = 16'h3C00;
    dev_rdata_en = 2'b10;
    check("rd1_no_early_en", bus_rdata_en, 0);
    tick();  // T+5
    dev_rdata_en = 2'b00;
    check("rd1_rdata_en", bus_rdata_en, 1);
    check("rd1_rdata", bus_rdata, 8'h3C);
    check("rd1_no_timeout", timeout_flag, 0);
    tick();  // T+6
    check("rd1_en_one_cycle", bus_rdata_en, 0);
    check("rd1_ready_back", bus_ready, 1);

    // Unmapped read 10h
    issue(8'h10, 0, 8'h00, 1);
    exp_q.push_back(8'hFF);
    tick();  // T+1
    bus_idle();
    check("unm_rdata_en", bus_rdata_en, 1);
    check("unm_rdata", bus_rdata, 8'hFF);
    check("unm_dev_valid", dev_valid, 0);
    tick();
    check("unm_en_drop", bus_rdata_en, 0);
    check("unm_ready", bus_ready, 1);
    check("unm_dev_valid2", dev_valid, 0);

    // Unmapped write 20h is discarded
    issue(8'h20, 1, 8'hAA, 1);
    tick();
    bus_idle();
    check("unw_ready", bus_ready, 1);
    check("unw_dev_valid", dev_valid, 0);
    check("unw_state", dbg_state, 0);

    // Read A0h with ready and rdata_en in the same cycle
    issue(8'hA0, 0, 8'h00, 1);
    exp_q.push_back(8'h5A);
    tick();  // T+1
    bus_idle();
    check("rd2_dev_valid", dev_valid, 2'b10);
    dev_ready = 2'b10;
    dev_rdata_en = 2'b10;
    dev_rdata = 16'h5A00;
    tick();  // T+2
    dev_ready = 2'b00;
    dev_rdata_en = 2'b00;
    check("rd2_rdata_en", bus_rdata_en, 1);
    check("rd2_rdata", bus_rdata, 8'h5A);
    tick();  // T+3
    check("rd2_ready", bus_ready, 1);

    // Reset asserted during RDWAIT
    issue(8'hA1, 0, 8'h00, 1);
    tick();  // T+1
    bus_idle();
    dev_ready = 2'b10;
    tick();  // T+2
    dev_ready = 2'b00;
    check("rs_in_rdwait", dbg_state, 2);
    check("rs_dev_ioreq_pre", dev_ioreq, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rs_bus_ready", bus_ready, 1);
    check("rs_bus_rdata", bus_rdata, 8'hFF);
    check("rs_rdata_en", bus_rdata_en, 0);
    check("rs_dev_valid", dev_valid, 0);
    check("rs_dev_address", dev_address, 0);
    check("rs_dev_ioreq", dev_ioreq, 0);
    check("rs_state", dbg_state, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Next read after reset completes normally (device 0, C3h)
    issue(8'h99, 0, 8'h00, 0);
    exp_q.push_back(8'hC3);
    tick();  // T+1
    bus_idle();
    check("rd3_dev_valid", dev_valid, 2'b01);
    dev_ready = 2'b01;
    tick();  // T+2
    dev_ready = 2'b00;
    dev_rdata = 16'h00C3;
    dev_rdata_en = 2'b01;
    tick();  // T+3
    dev_rdata_en = 2'b00;
    check("rd3_rdata_en", bus_rdata_en, 1);
    check("rd3_rdata", bus_rdata, 8'hC3);
    tick();
    check("rd3_ready", bus_ready, 1);

    // Read timeout: 98h, device 0 silent; device 1 strobes and is ignored
    issue(8'h98, 0, 8'h00, 1);
    exp_q.push_back(8'hFF);
    tick();  // T+1
    bus_idle();
    check("to_dev_valid", dev_valid, 2'b01);
    tick();  // T+2
    dev_rdata = 16'h7700;
    dev_rdata_en = 2'b10;
    tick();  // T+3
    dev_rdata_en = 2'b00;
    tick();  // T+4
    check("to_valid_still", dev_valid, 2'b01);
    check("to_flag_pre", timeout_flag, 0);
    tick();  // T+5
    check("to_valid_drop", dev_valid, 0);
    check("to_rdata_en", bus_rdata_en, 1);
    check("to_rdata", bus_rdata, 8'hFF);
    check("to_flag_set", timeout_flag, 1);
    tick();  // T+6
    timeout_clear = 1'b1;
    check("to_flag_sticky", timeout_flag, 1);
    tick();  // T+7
    timeout_clear = 1'b0;
    check("to_flag_cleared", timeout_flag, 0);

    // Write timeout with timeout_clear held across the expiry: set wins
    issue(8'h9A, 1, 8'h11, 1);
    tick();  // T+1
    bus_idle();
    timeout_clear = 1'b1;
    check("wto_dev_valid", dev_valid, 2'b01);
    repeat (3) tick();  // T+4
    check("wto_valid_still", dev_valid, 2'b01);
    tick();  // T+5
    timeout_clear = 1'b0;
    check("wto_valid_drop", dev_valid, 0);
    check("wto_ready", bus_ready, 1);
    check("wto_flag_set_wins", timeout_flag, 1);
    timeout_clear = 1'b1;
    tick();
    timeout_clear = 1'b0;
    check("wto_flag_cleared", timeout_flag, 0);

    // Interrupt aggregation, one cycle of latency
    dev_int_n = 2'b01;
    check("int_not_yet", int_n, 1);
    tick();
    check("int_asserted", int_n, 0);
    dev_int_n = 2'b11;
    tick();
    check("int_released", int_n, 1);

    // Overlapping decode on the second instance: 98h goes to device 0
    b_address = 8'h98;
    b_write = 1'b0;
    b_ioreq = 1'b1;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    check("ovl_dev_valid", b_dev_valid, 2'b01);
    b_dev_ready = 2'b01;
    b_dev_rdata_en = 2'b01;
    b_dev_rdata = 16'hEEA5;
    tick();
    b_dev_ready = 2'b00;
    b_dev_rdata_en = 2'b00;
    check("ovl_rdata_en", b_rdata_en, 1);
    check("ovl_rdata", b_rdata, 8'hA5);

    tick();
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
